// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, arbiter state encoding and owner codes for mem_arbiter
package riscv_pkg;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} arb_state_t;
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the fetch and data requesters
//   i_fetch_valid, i_data_valid : pending requests
//   i_last                      : owner granted last (only with MEM_ARB_RR_EN)
//   o_winner                    : OWN_D or OWN_I, meaningful only while a request is pending
//   MEM_ARB_RR_EN               : round-robin ties instead of fixed data priority
module mem_arb_pick
   import riscv_pkg::*;
(
   input  logic i_fetch_valid,
   input  logic i_data_valid,
`ifdef MEM_ARB_RR_EN
   input  logic i_last,
`endif
   output logic o_winner
);
`ifdef MEM_ARB_RR_EN
   // on a tie the port not granted last wins
   assign o_winner = (i_data_valid && (!i_fetch_valid || i_last == OWN_I)) ? OWN_D : OWN_I;
`else
   assign o_winner = i_data_valid ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store, one transaction outstanding
//   clk, reset (async, active-low)
//   i_req_* / i_rsp_* : fetch read request and response
//   d_req_* / d_rsp_* : load/store request and response
//   mem_req_* / mem_rsp_* : shared memory port
//   busy, owner : transaction in flight, and which port owns it
//   MEM_ARB_RR_EN : round-robin tie breaking (default: data port wins ties)
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_rsp_valid,
   output logic [DATA_W-1:0]   i_rsp_data,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_we,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   output logic                busy,
   output logic                owner
);
   arb_state_t r_state, w_next;
   logic r_owner, r_we, w_winner, w_accept;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
`ifdef MEM_ARB_RR_EN
   logic r_last;
`endif
   mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
      .i_last        (r_last),
`endif
      .i_fetch_valid (i_req_valid),
      .i_data_valid  (d_req_valid),
      .o_winner      (w_winner)
   );
   always_comb begin
      w_next = r_state;
      w_accept = 1'b0;
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      mem_req_valid = 1'b0;
      case (r_state)
         IDLE: begin
            // nothing is offered while reset is held, so the first accept follows release
            w_accept = reset && (i_req_valid || d_req_valid);
            i_req_ready = w_accept && w_winner == OWN_I;
            d_req_ready = w_accept && w_winner == OWN_D;
            w_next = w_accept ? REQ : IDLE;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            w_next = mem_req_ready ? WAIT_RSP : REQ;
         end
         WAIT_RSP: begin
            i_rsp_valid = mem_rsp_valid && r_owner == OWN_I;
            d_rsp_valid = mem_rsp_valid && r_owner == OWN_D;
            w_next = mem_rsp_valid ? IDLE : WAIT_RSP;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_owner <= OWN_I;
         r_addr <= '0;
         r_we <= 1'b0;
         r_wdata <= '0;
         r_wstrb <= '0;
`ifdef MEM_ARB_RR_EN
         r_last <= OWN_I;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_owner <= w_winner;
            r_addr <= (w_winner == OWN_D) ? d_addr : i_addr;
            r_we <= (w_winner == OWN_D) && d_we;
            r_wdata <= (w_winner == OWN_D) ? d_wdata : '0;
            r_wstrb <= (w_winner == OWN_D) ? d_wstrb : '0;
`ifdef MEM_ARB_RR_EN
            r_last <= w_winner;
`endif
         end
      end
   end
   assign mem_addr = r_addr;
   assign mem_we = r_we;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign i_rsp_data = mem_rsp_data;
   assign d_rsp_data = mem_rsp_data;
   assign busy = r_state != IDLE;
   assign owner = r_owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus corner sequences, scoreboard on memory and response ports
module tb_mem_arbiter;
   import riscv_pkg::*;
   localparam logic [31:0] K = 32'h0050_0083;
   logic clk = 1'b0, reset = 1'b0;
   logic i_req_valid = 1'b0, d_req_valid = 1'b0, d_we = 1'b0, mem_req_ready = 1'b1;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0] d_wstrb = '0;
   logic i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid, mem_req_valid, mem_we, busy, owner;
   logic [31:0] i_rsp_data, d_rsp_data, mem_addr, mem_wdata, mem_rsp_data;
   logic [3:0] mem_wstrb;
   logic mem_rsp_valid;
   logic model_en = 1'b1, model_v = 1'b0, force_v = 1'b0;
   logic [31:0] model_d = '0, force_d = '0;
   typedef struct {logic own; logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} txn_t;
   typedef struct {logic iv; logic [31:0] ia; logic dv; logic [31:0] da; logic we; logic [31:0] wd; logic [3:0] ws; logic exp_d;} vec_t;
   txn_t q_mem[$], q_rsp[$];
   vec_t tbl[6];
   int n_chk = 0, n_fail = 0;
`ifdef MEM_ARB_RR_EN
   logic model_last = 1'b0;
`endif
   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .busy(busy), .owner(owner)
   );
   always #5 clk = ~clk;
   assign mem_rsp_valid = model_v | force_v;
   assign mem_rsp_data = force_v ? force_d : model_d;
   // memory model: response one cycle after the request handshake, data derived from the address
   always @(posedge clk) begin
      model_v <= model_en && mem_req_valid && mem_req_ready;
      model_d <= mem_addr ^ K;
   end
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin : mon
      txn_t t;
`ifdef MEM_ARB_RR_EN
      if (!reset) model_last = 1'b0;
`endif
      if (reset) begin
         if (busy) check("ready_busy", {i_req_ready, d_req_ready}, 0);
         if (d_req_valid && d_req_ready) begin
            q_mem.push_back('{1'b1, d_addr, d_we, d_wdata, d_wstrb});
`ifdef MEM_ARB_RR_EN
            model_last = 1'b1;
`endif
         end
         if (i_req_valid && i_req_ready) begin
            q_mem.push_back('{1'b0, i_addr, 1'b0, 32'h0, 4'h0});
`ifdef MEM_ARB_RR_EN
            model_last = 1'b0;
`endif
         end
         if (mem_req_valid && mem_req_ready) begin
            if (q_mem.size() == 0) check("mem_unexpected", {63'b0, mem_req_valid}, 0);
            else begin
               t = q_mem.pop_front();
               check("mem_addr", mem_addr, t.addr);
               check("mem_we", mem_we, t.we);
               check("mem_wdata", mem_wdata, t.wdata);
               check("mem_wstrb", mem_wstrb, t.wstrb);
               q_rsp.push_back(t);
            end
         end
         if (i_rsp_valid || d_rsp_valid) begin
            if (q_rsp.size() == 0) check("rsp_unexpected", {i_rsp_valid, d_rsp_valid}, 0);
            else begin
               t = q_rsp.pop_front();
               check("rsp_owner", {i_rsp_valid, d_rsp_valid}, t.own ? 2'b01 : 2'b10);
               check("rsp_data", t.own ? d_rsp_data : i_rsp_data, t.addr ^ K);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input string nm);
      int n = 0;
      while ((busy || q_mem.size() != 0 || q_rsp.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_drain"}, {62'b0, busy, (q_mem.size() != 0 || q_rsp.size() != 0)}, 0);
      tick();
   endtask
   task automatic run_vec(input vec_t v, input string nm);
      logic pi, pd, first, exp_d;
      int n = 0;
      i_req_valid = v.iv; i_addr = v.ia;
      d_req_valid = v.dv; d_addr = v.da; d_we = v.we; d_wdata = v.wd; d_wstrb = v.ws;
      pi = v.iv; pd = v.dv; first = 1'b1;
      exp_d = v.exp_d;
`ifdef MEM_ARB_RR_EN
      if (v.iv && v.dv) exp_d = (model_last == OWN_I);
`endif
      while ((pi || pd) && n < 40) begin
         @(negedge clk);
         if (i_req_ready || d_req_ready) begin
            check({nm, "_one_ready"}, {63'b0, i_req_ready & d_req_ready}, 0);
            if (first) check({nm, "_first_winner"}, {63'b0, d_req_ready}, {63'b0, exp_d});
            first = 1'b0;
            if (i_req_ready) pi = 1'b0;
            if (d_req_ready) pd = 1'b0;
         end
         tick();
         i_req_valid = pi;
         d_req_valid = pd;
         n++;
      end
      if (pi || pd) check({nm, "_accept_timeout"}, {62'b0, pi, pd}, 0);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      drain(nm);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic got[4];
      int k, n;
      tbl[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[1] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1};
      tbl[2] = '{1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 1'b1};
      tbl[3] = '{1'b0, 32'h0, 1'b1, 32'h0000_0044, 1'b1, 32'h1234_5678, 4'h3, 1'b1};
      tbl[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[5] = '{1'b1, 32'h0000_0030, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 4'h0, 1'b1};
      // reset state with requests and a stray response present
      force_v = 1'b1; force_d = 32'hFFFF_FFFF;
      i_req_valid = 1'b1; i_addr = 32'h88;
      d_req_valid = 1'b1; d_addr = 32'h1234; d_we = 1'b1; d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy_owner", {busy, owner}, 2'b00);
      check("rst_ready", {i_req_ready, d_req_ready}, 2'b00);
      check("rst_rsp_valid", {i_rsp_valid, d_rsp_valid}, 2'b00);
      check("rst_mem_valid_we", {mem_req_valid, mem_we}, 2'b00);
      check("rst_fields", {mem_addr, mem_wdata}, 64'h0);
      check("rst_wstrb", mem_wstrb, 4'h0);
      tick();
      force_v = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0; reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
      // back-pressure: memory not ready for 5 cycles, fetch waiting meanwhile
      mem_req_ready = 1'b0;
      d_req_valid = 1'b1; d_addr = 32'h80; d_we = 1'b1; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hC;
      i_req_valid = 1'b1; i_addr = 32'h40;
      @(negedge clk);
      check("bp_accept", {i_req_ready, d_req_ready}, 2'b01);
      tick();
      d_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", {mem_req_valid, mem_we, i_req_ready, d_req_ready}, 4'b1100);
         check("bp_hold_fields", {mem_addr, mem_wdata}, {32'h80, 32'hCAFE_F00D});
         check("bp_hold_wstrb", mem_wstrb, 4'hC);
      end
      tick();
      mem_req_ready = 1'b1; i_req_valid = 1'b0;
      drain("bp");
      // reset while waiting for the response, then a late response
      model_en = 1'b0;
      i_req_valid = 1'b1; i_addr = 32'h50;
      tick();
      i_req_valid = 1'b0;
      tick();
      @(negedge clk);
      check("rw_in_wait", {busy, mem_req_valid}, 2'b10);
      reset = 1'b0;
      #1;
      check("rw_busy_after_rst", {busy, mem_req_valid}, 2'b00);
      q_mem.delete(); q_rsp.delete();
      tick(); tick();
      reset = 1'b1; force_v = 1'b1; force_d = 32'h0000_0077;
      @(negedge clk);
      check("rw_late_rsp", {i_rsp_valid, d_rsp_valid, busy}, 3'b000);
      tick();
      force_v = 1'b0; model_en = 1'b1;
      run_vec(tbl[0], "after_rst");
      // stray response while idle
      force_v = 1'b1; force_d = 32'h0BAD_0BAD;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stray_idle", {i_rsp_valid, d_rsp_valid, busy}, 3'b000);
      end
      tick();
      force_v = 1'b0;
      @(negedge clk);
      check("stray_stays_idle", {62'b0, busy, mem_req_valid}, 0);
      // both ports continuously valid for four grants, from a fresh reset
      tick();
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      i_req_valid = 1'b1; i_addr = 32'h60;
      d_req_valid = 1'b1; d_addr = 32'h600; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
      k = 0; n = 0;
      while (k < 4 && n < 60) begin
         @(negedge clk);
         if (d_req_ready) got[k++] = 1'b1;
         else if (i_req_ready) got[k++] = 1'b0;
         tick();
         n++;
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      check("grant_count", k, 4);
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
         check($sformatf("grant%0d", i), {63'b0, got[i]}, (i % 2 == 0) ? 1 : 0);
`else
         check($sformatf("grant%0d", i), {63'b0, got[i]}, 1);
`endif
      end
      drain("grants");
      check("final_queues", q_mem.size() + q_rsp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_req_valid in 1, i_req_ready out 1, i_addr in ADDR_W: instruction-fetch read request.
REQ-006 SHALL have ports i_rsp_valid out 1, i_rsp_data out DATA_W: fetch response.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_addr in ADDR_W, d_we in 1, d_wdata in DATA_W, d_wstrb in DATA_W/8: load/store request.
REQ-008 SHALL have ports d_rsp_valid out 1, d_rsp_data out DATA_W: load data / store ack.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W, mem_we out 1, mem_wdata out DATA_W, mem_wstrb out DATA_W/8: shared memory port.
REQ-010 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in DATA_W: memory response.
REQ-011 SHALL have ports busy out 1 (state not IDLE) and owner out 1 (0 = fetch, 1 = data).

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT_RSP; at most one transaction outstanding.
REQ-013 In IDLE with any valid, SHALL pulse the winner's *_req_ready for one cycle, latch its addr/we/wdata/wstrb, set owner, and go to REQ; the loser's ready stays 0.
REQ-014 *_req_ready SHALL be 0 in REQ and WAIT_RSP; a request is accepted only when valid and ready are both 1.
REQ-015 Fixed priority: on simultaneous requests the data port SHALL win.
REQ-016 Fetch requests SHALL drive mem_we=0 and mem_wstrb=0.
REQ-017 In REQ, mem_req_valid SHALL be 1 with latched fields held stable until mem_req_ready=1, then go to WAIT_RSP.
REQ-018 In WAIT_RSP, mem_rsp_valid SHALL be routed combinationally to the owner's *_rsp_valid; mem_rsp_data SHALL drive both *_rsp_data. The FSM SHALL return to IDLE on the following edge.
REQ-019 mem_rsp_valid outside WAIT_RSP SHALL be ignored; no *_rsp_valid is asserted.
REQ-020 Minimum request-to-response spacing: accept (cycle 0), mem_req_valid (cycle 1), response no earlier than cycle 2, next accept no earlier than cycle 3.
REQ-021 A requester SHALL receive exactly one response per accepted request, in order.

Reset
REQ-022 While reset=0: state IDLE, owner=0, busy=0, all *_ready, *_rsp_valid and mem_req_valid 0, latched fields 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it; a later mem_rsp_valid SHALL be discarded per REQ-019.
REQ-024 The first acceptance SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-025 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the port not granted last wins. The last-grant register resets to fetch, so data wins the first tie.
REQ-026 Without MEM_ARB_RR_EN, REQ-015 fixed priority applies and no last-grant register exists.

Structure
REQ-027 riscv_pkg SHALL hold ADDR_W/DATA_W defaults, the arb_state_t enum (IDLE/REQ/WAIT_RSP) and owner constants OWN_I=0, OWN_D=1.
REQ-028 Winner selection SHALL be a combinational sub-module mem_arb_pick; the FSM and datapath latches remain in mem_arbiter.

Verification
REQ-029 Fetch only: i_addr=0x0000_0010, memory with ready=1 and 1-cycle response 0x0050_0093 -> one i_req_ready pulse, mem_addr=0x10, mem_we=0, i_rsp_data=0x0050_0093, d_rsp_valid stays 0.
REQ-030 Simultaneous requests, fixed priority: i_addr=0x20, d store to 0x100 with wdata=0xDEAD_BEEF and wstrb=0xF -> data is served first (mem_we=1), then fetch 0x20; two responses total, in that order.
REQ-031 Back-pressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields stable for all 5 cycles, no *_req_ready asserted.
REQ-032 Reset during WAIT_RSP, then mem_rsp_valid=1 after release -> no i_rsp_valid or d_rsp_valid; busy=0; next request served normally.
REQ-033 MEM_ARB_RR_EN: both ports continuously valid for 4 transactions -> grant order D, I, D, I.
REQ-034 Stray mem_rsp_valid=1 in IDLE -> no response outputs asserted, state stays IDLE.
